bram_arbiter: RTL and testbench
===============================

# bram_arbiter

Shares one single-port block RAM between the core's instruction-fetch port, the core's data port, and the UART program loader. A BOOT/RUN sequencer holds the core in reset while the loader writes the program, then releases it. In RUN, the loader keeps absolute priority and the two core ports alternate round-robin. The block sits between the core/loader and the BRAM primitive, which has 1-cycle read latency.

## Interface
- MEM, 10: log2 of memory size in bytes; word address width is MEM-2.
- BOOT_SKIP, 0: 1 = reset directly into RUN (memory preloaded, no loader).

- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- core_rstn  out  1  reset to core, active-low, registered
- loader_done  in  1  single-cycle pulse: program load complete
- ld_req  in  1  loader write request
- ld_addr  in  MEM-2  loader word address
- ld_wdata  in  32  loader write data
- ld_gnt  out  1  loader request accepted this cycle
- if_req  in  1  fetch read request
- if_addr  in  MEM-2  fetch word address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  if_rdata valid
- if_rdata  out  32  fetch read data
- d_req  in  1  data request
- d_we  in  1  data write (1) / read (0)
- d_addr  in  MEM-2  data word address
- d_wdata  in  32  data write data
- d_gnt  out  1  data accepted this cycle
- d_rvalid  out  1  d_rdata valid
- d_rdata  out  32  data read data
- bram_en  out  1  BRAM enable
- bram_we  out  1  BRAM write enable
- bram_addr  out  MEM-2  BRAM word address
- bram_din  out  32  BRAM write data
- bram_dout  in  32  BRAM read data, valid 1 cycle after a read issue

## Operation
- State register: BOOT or RUN. Reset value: BOOT, or RUN if BOOT_SKIP=1.
- BOOT: only ld_req is granted; if_gnt and d_gnt stay 0. loader_done=1 moves the state to RUN at the next edge. A ld_req in the same cycle as loader_done is still granted.
- RUN: priority is ld_req > core ports. When if_req and d_req are both asserted with no ld_req, the grant goes to the port not granted last (last-grant pointer). The pointer resets to "if", so data wins the first tie. The pointer updates only on core-port grants. loader_done is ignored in RUN.
- Exactly one gnt per cycle at most. gnt is combinational from the req inputs and the registered state. While rstn=0, all gnt are forced to 0.
- The granted port drives bram_addr, bram_din, and bram_we (the loader always writes). bram_en = any gnt. With no grant, bram_en=0, bram_we=0, and addr/din are don't-care.
- Requesters hold req, addr, we, and wdata stable until they see gnt. A request is consumed by one gnt.
- Read return: on a granted read, a registered tag (if/d) is set, and next cycle the matching rvalid is 1 for exactly one cycle. if_rdata and d_rdata are both wired to bram_dout and are valid only while their rvalid is high.
- Writes produce no rvalid.
- core_rstn register: reset 0; next value = (state == RUN).
- rstn low mid-operation: the state returns to BOOT (unless BOOT_SKIP), and the rvalid tags clear. Any read in flight is dropped with no rvalid.

## Timing
- Grant latency: 0 cycles. A request is granted in the cycle it is asserted if it wins arbitration.
- Read data latency: rvalid is asserted 1 cycle after gnt. Back-to-back reads from the same port give one rvalid per cycle.
- Write: committed at the edge ending the gnt cycle.
- Reset values: core_rstn=0, if_rvalid=0, d_rvalid=0, all gnt=0, bram_en=0, bram_we=0.
- BOOT_SKIP=1: core_rstn=1 from the first edge after rstn deasserts.
- BOOT_SKIP=0: core_rstn=1 from the second edge after the loader_done pulse: one edge to enter RUN, one for the core_rstn register. The core's first request is therefore always in RUN.
- Loader write and core read in the same RUN cycle: the loader wins, and the core request waits at least 1 cycle.

## Test plan
- BOOT load: ld writes 0xDEADBEEF to word 0x20 and 0x00000013 to word 0x21, pulse loader_done. Expect ld_gnt each cycle, core_rstn=0 until 2 edges after loader_done, then 1. if_req during BOOT gets no if_gnt.
- Fetch read: in RUN, if_req with if_addr=0x20. Expect if_gnt the same cycle, then if_rvalid=1 with if_rdata=0xDEADBEEF the next cycle, d_rvalid=0.
- Tie round-robin: if_req and d_req (read 0x21) held continuously from reset-to-RUN. Expect grant order d, if, d, if, and rvalid routed to the port granted the previous cycle.
- Loader preemption: ld_req, if_req, and d_req all asserted in RUN. Expect ld_gnt first with bram_we=1, then round-robin resumes without moving the pointer for the loader cycle.
- Data write then read: d_we=1 writes 0x12345678 to 0x30, then a read of 0x30. Expect no rvalid for the write and d_rdata=0x12345678 on d_rvalid.
- Reset mid-read: rstn=0 the cycle after d_gnt for a read. Expect d_rvalid=0, the state back in BOOT, and core_rstn=0.

Source files
------------

// File: rtl/bram_arbiter.sv
// Arbitrates one single-port BRAM between the UART loader, instruction fetch and data port.
// A BOOT/RUN sequencer holds the core in reset until the loader signals completion.
module bram_arbiter #(
    parameter int MEM       = 10,
    parameter bit BOOT_SKIP = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    output logic             core_rstn_o,
    input  logic             loader_done_i,
    input  logic             ld_req_i,
    input  logic [MEM-3:0]   ld_addr_i,
    input  logic [31:0]      ld_wdata_i,
    output logic             ld_gnt_o,
    input  logic             if_req_i,
    input  logic [MEM-3:0]   if_addr_i,
    output logic             if_gnt_o,
    output logic             if_rvalid_o,
    output logic [31:0]      if_rdata_o,
    input  logic             d_req_i,
    input  logic             d_we_i,
    input  logic [MEM-3:0]   d_addr_i,
    input  logic [31:0]      d_wdata_i,
    output logic             d_gnt_o,
    output logic             d_rvalid_o,
    output logic [31:0]      d_rdata_o,
    output logic             bram_en_o,
    output logic             bram_we_o,
    output logic [MEM-3:0]   bram_addr_o,
    output logic [31:0]      bram_din_o,
    input  logic [31:0]      bram_dout_i,
    output logic             state_o
);

    typedef enum logic {ST_BOOT = 1'b0, ST_RUN = 1'b1} state_t;

    localparam state_t RESET_STATE = BOOT_SKIP ? ST_RUN : ST_BOOT;

    state_t state_q, state_d;
    logic   last_d_q, last_d_d;
    logic   rv_if_q, rv_if_d;
    logic   rv_d_q, rv_d_d;
    logic   core_rstn_q, core_rstn_d;

    // Handshake: a requester holds req/addr/we/wdata stable until it sees gnt in
    // the same cycle; that single gnt consumes the request. Reads return one
    // cycle after gnt with a single-cycle rvalid.

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_BOOT && loader_done_i) begin
            state_d = ST_RUN;
        end
    end

    // Loader always wins; core ports only compete in RUN, tie broken by last grant.
    always_comb begin
        ld_gnt_o = 1'b0;
        if_gnt_o = 1'b0;
        d_gnt_o  = 1'b0;
        if (rstn) begin
            if (ld_req_i) begin
                ld_gnt_o = 1'b1;
            end else if (state_q == ST_RUN) begin
                if (if_req_i && d_req_i) begin
                    if_gnt_o = last_d_q;
                    d_gnt_o  = ~last_d_q;
                end else begin
                    if_gnt_o = if_req_i;
                    d_gnt_o  = d_req_i;
                end
            end
        end
    end

    always_comb begin
        bram_we_o   = 1'b0;
        bram_addr_o = '0;
        bram_din_o  = '0;
        if (ld_gnt_o) begin
            bram_we_o   = 1'b1;
            bram_addr_o = ld_addr_i;
            bram_din_o  = ld_wdata_i;
        end else if (if_gnt_o) begin
            bram_addr_o = if_addr_i;
        end else if (d_gnt_o) begin
            bram_we_o   = d_we_i;
            bram_addr_o = d_addr_i;
            bram_din_o  = d_wdata_i;
        end
    end

    assign bram_en_o = ld_gnt_o | if_gnt_o | d_gnt_o;

    always_comb begin
        last_d_d    = last_d_q;
        if (if_gnt_o) begin
            last_d_d = 1'b0;
        end else if (d_gnt_o) begin
            last_d_d = 1'b1;
        end
        rv_if_d     = if_gnt_o;
        rv_d_d      = d_gnt_o & ~d_we_i;
        core_rstn_d = (state_q == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_d_q    <= 1'b0;
            rv_if_q     <= 1'b0;
            rv_d_q      <= 1'b0;
            core_rstn_q <= 1'b0;
        end else begin
            last_d_q    <= last_d_d;
            rv_if_q     <= rv_if_d;
            rv_d_q      <= rv_d_d;
            core_rstn_q <= core_rstn_d;
        end
    end

    // Gating with rstn drops a read whose return cycle coincides with reset.
    assign if_rvalid_o = rv_if_q & rstn;
    assign d_rvalid_o  = rv_d_q & rstn;
    assign if_rdata_o  = bram_dout_i;
    assign d_rdata_o   = bram_dout_i;
    assign core_rstn_o = core_rstn_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed plus randomized bench for bram_arbiter with a BRAM model and a
// reference model built from the arbitration rules (priority, alternation, BOOT/RUN).
module tb_bram_arbiter;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          core_rstn;
  logic          loader_done;
  logic          ld_req;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_wdata;
  logic          ld_gnt;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;
  logic          bram_en;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_din;
  logic [31:0]   bram_dout;
  logic          state_dbg;

  bram_arbiter #(.MEM(10), .BOOT_SKIP(1'b0)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .core_rstn_o   (core_rstn),
    .loader_done_i (loader_done),
    .ld_req_i      (ld_req),
    .ld_addr_i     (ld_addr),
    .ld_wdata_i    (ld_wdata),
    .ld_gnt_o      (ld_gnt),
    .if_req_i      (if_req),
    .if_addr_i     (if_addr),
    .if_gnt_o      (if_gnt),
    .if_rvalid_o   (if_rvalid),
    .if_rdata_o    (if_rdata),
    .d_req_i       (d_req),
    .d_we_i        (d_we),
    .d_addr_i      (d_addr),
    .d_wdata_i     (d_wdata),
    .d_gnt_o       (d_gnt),
    .d_rvalid_o    (d_rvalid),
    .d_rdata_o     (d_rdata),
    .bram_en_o     (bram_en),
    .bram_we_o     (bram_we),
    .bram_addr_o   (bram_addr),
    .bram_din_o    (bram_din),
    .bram_dout_i   (bram_dout),
    .state_o       (state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  // BRAM primitive: 1-cycle read latency
  logic [31:0] bram_mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) bram_mem[bram_addr] <= bram_din;
      else         bram_dout <= bram_mem[bram_addr];
    end
  end

  // reference model
  logic [31:0] ref_mem [0:(1<<AW)-1];
  bit          m_run;
  bit          m_last_if;
  bit          m_core;
  bit          exp_rv_if;
  bit          exp_rv_d;
  logic [31:0] exp_rdata;
  bit          g_ld, g_if, g_d;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs already driven; check, update model, advance.
  task automatic step();
    logic exp_we;
    #2;
    g_ld = 1'b0; g_if = 1'b0; g_d = 1'b0;
    if (rstn) begin
      if (ld_req) g_ld = 1'b1;
      else if (m_run) begin
        if (if_req && d_req) begin
          if (m_last_if) g_d = 1'b1;
          else           g_if = 1'b1;
        end else begin
          g_if = if_req;
          g_d  = d_req;
        end
      end
    end
    exp_we = g_ld | (g_d & d_we);
    check("ld_gnt", ld_gnt, g_ld);
    check("if_gnt", if_gnt, g_if);
    check("d_gnt", d_gnt, g_d);
    check("bram_en", bram_en, g_ld | g_if | g_d);
    check("bram_we", bram_we, exp_we);
    if (g_ld) check("bram_addr_ld", bram_addr, ld_addr);
    if (g_if) check("bram_addr_if", bram_addr, if_addr);
    if (g_d)  check("bram_addr_d", bram_addr, d_addr);
    if (g_ld) check("bram_din_ld", bram_din, ld_wdata);
    if (g_d && d_we) check("bram_din_d", bram_din, d_wdata);
    check("core_rstn", core_rstn, m_core);
    check("state", state_dbg, m_run);
    check("if_rvalid", if_rvalid, exp_rv_if & rstn);
    check("d_rvalid", d_rvalid, exp_rv_d & rstn);
    if (exp_rv_if && rstn) check("if_rdata", if_rdata, exp_rdata);
    if (exp_rv_d && rstn)  check("d_rdata", d_rdata, exp_rdata);

    if (!rstn) begin
      m_run     = 1'b0;
      m_last_if = 1'b1;
      m_core    = 1'b0;
      exp_rv_if = 1'b0;
      exp_rv_d  = 1'b0;
    end else begin
      m_core    = m_run;
      exp_rv_if = g_if;
      exp_rv_d  = g_d & ~d_we;
      if (g_if) exp_rdata = ref_mem[if_addr];
      if (g_d && !d_we) exp_rdata = ref_mem[d_addr];
      if (g_ld) ref_mem[ld_addr] = ld_wdata;
      if (g_d && d_we) ref_mem[d_addr] = d_wdata;
      if (g_if) m_last_if = 1'b1;
      if (g_d)  m_last_if = 1'b0;
      if (!m_run && loader_done) m_run = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    loader_done = 1'b0;
    ld_req = 1'b0; ld_addr = '0; ld_wdata = '0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
  endtask

  bit p_ld, p_if, p_d;

  initial begin
    for (int i = 0; i < (1<<AW); i++) begin
      bram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    bram_dout = '0;
    exp_rdata = '0;
    m_run = 1'b0; m_last_if = 1'b1; m_core = 1'b0;
    exp_rv_if = 1'b0; exp_rv_d = 1'b0;
    idle_inputs();
    rstn = 1'b0;
    @(posedge clk); #1;

    // reset: requests must not be granted
    ld_req = 1'b1; if_req = 1'b1;
    step();
    step();

    // BOOT load, fetch request ignored
    rstn = 1'b1;
    ld_req = 1'b1; ld_addr = 8'h20; ld_wdata = 32'hDEADBEEF;
    if_req = 1'b1; if_addr = 8'h20;
    step();
    ld_addr = 8'h21; ld_wdata = 32'h00000013; loader_done = 1'b1;
    step();
    idle_inputs();
    step();
    step();

    // fetch read
    if_req = 1'b1; if_addr = 8'h20;
    step();
    idle_inputs();
    step();

    // tie round-robin
    if_req = 1'b1; if_addr = 8'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h21;
    for (int i = 0; i < 4; i++) step();

    // loader preemption
    ld_req = 1'b1; ld_addr = 8'h40; ld_wdata = $urandom;
    step();
    ld_req = 1'b0;
    step();
    step();
    idle_inputs();
    step();

    // data write then read
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h30; d_wdata = 32'h12345678;
    step();
    d_we = 1'b0;
    step();
    idle_inputs();
    step();

    // random traffic with hold-until-grant
    p_ld = 1'b0; p_if = 1'b0; p_d = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!p_ld && $urandom_range(0, 5) == 0) begin
        p_ld = 1'b1; ld_addr = AW'($urandom_range(0, 31)); ld_wdata = $urandom;
      end
      if (!p_if && $urandom_range(0, 2) != 0) begin
        p_if = 1'b1; if_addr = AW'($urandom_range(0, 31));
      end
      if (!p_d && $urandom_range(0, 2) != 0) begin
        p_d = 1'b1; d_addr = AW'($urandom_range(0, 31));
        d_we = $urandom_range(0, 1) == 1; d_wdata = $urandom;
      end
      ld_req = p_ld; if_req = p_if; d_req = p_d;
      loader_done = $urandom_range(0, 15) == 0;
      step();
      if (g_ld) p_ld = 1'b0;
      if (g_if) p_if = 1'b0;
      if (g_d)  p_d  = 1'b0;
    end
    idle_inputs();
    step();

    // reset in the cycle after a data read grant
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h30;
    step();
    idle_inputs();
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
